// File: rtl/keypad_event_filter_pkg.sv
// keypad_pkg: shared types and constants for the keypad event filter.
//
// Contents
//   state_t   : filter FSM states (IDLE, CAND, HELD)
//   verdict_t : per-frame verdict (NONE, CONFLICT, KEY)
//   KEY_*     : key codes the game uses for the four arrows
//   DEF_FRAME_CYCLES : one full 4-column scan frame at 100 MHz
//   frame_verdict()  : reduces a frame's hit/conflict flags to a verdict
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        CONFLICT = 2'd1,
        KEY      = 2'd2
    } verdict_t;

    localparam logic [3:0] KEY_UP    = 4'h2;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_DOWN  = 4'h8;

    localparam int DEF_FRAME_CYCLES = 400000;

    // A conflict outranks a hit: two different keys in one frame are
    // treated as no usable key at all.
    function automatic verdict_t frame_verdict(input logic hit, input logic conflict);
        if (conflict) begin
            return CONFLICT;
        end else if (hit) begin
            return KEY;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/keypad_event_filter_if.sv
// keypad_event_filter_if: key-event handshake between the filter and the
// game logic.
//
// Signals
//   evt_valid : producer has a head event
//   evt_ready : consumer accepts the head event
//   evt_key   : head event key code
//
// Handshake: an event transfers on every rising clk edge where
// evt_valid && evt_ready. While evt_valid=1 and evt_ready=0 the producer
// holds evt_valid and evt_key unchanged. evt_ready may be asserted at any
// time, including while evt_valid=0 (no transfer then).
interface keypad_event_filter_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_key;

    modport master (output evt_valid, output evt_key, input evt_ready);
    modport slave  (input evt_valid, input evt_key, output evt_ready);
endinterface

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: small first-word-fall-through FIFO for key events.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and data
//   pop        : read request; ignored while empty
//   dout       : head entry while non-empty, 0 while empty
//   full/empty : occupancy flags
//   drop       : push refused this cycle (full and no pop in the same cycle)
module keypad_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_N);
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: dout is gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/keypad_event_filter.sv
// keypad_event_filter: turns the column scanner's key_value/key_pressed
// levels into debounced single-shot key events plus a debounced held level.
//
// Each scan frame of FRAME_CYCLES clocks is reduced to one verdict (NONE,
// CONFLICT or KEY(k)) in its last cycle. A key must give STABLE_FRAMES
// consecutive KEY(k) verdicts before one event is queued in an FWFT FIFO.
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   key_value   : decoded key code from the scanner
//   key_pressed : scanner saw a key in the current column
//   evt         : event handshake (evt_valid/evt_ready/evt_key), master side
//   held        : debounced key-held level
//   held_key    : held key code while held=1, else 0
//   overflow    : one-cycle pulse when an event is dropped on a full FIFO
//   dbg_state   : current FSM state
//
// Build option
//   KEYPAD_AUTOREPEAT_EN : while HELD, emit a repeat event every
//                          REPEAT_FRAMES KEY(held_key) verdicts.
module keypad_event_filter
    import keypad_pkg::*;
#(
    parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES,
    parameter int STABLE_FRAMES = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    key_value,
    input  logic                          key_pressed,
    keypad_event_filter_if.master         evt,
    output logic                          held,
    output logic [3:0]                    held_key,
    output logic                          overflow,
    output state_t                        dbg_state
);

    localparam int FW = $clog2(FRAME_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [4:0]    STABLE_N   = 5'(STABLE_FRAMES);

    if (!(FRAME_CYCLES >= 8 && STABLE_FRAMES >= 1 && STABLE_FRAMES <= 15 &&
          FIFO_DEPTH >= 2 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0 &&
          REPEAT_FRAMES >= 1)) begin : g_bad_params
        $error("keypad_event_filter: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Frame accumulation
    // ------------------------------------------------------------------
    logic [FW-1:0] frame_cnt;
    logic          frame_wrap;
    logic          hit;
    logic [3:0]    hit_key;
    logic          conflict;

    logic          samp_hit;
    logic [3:0]    samp_key;
    logic          samp_conflict;
    verdict_t      verdict;

    assign frame_wrap = (frame_cnt == FRAME_LAST);

    // The verdict includes the sample taken in the wrap cycle itself.
    assign samp_hit      = hit | key_pressed;
    assign samp_key      = hit ? hit_key : key_value;
    assign samp_conflict = conflict | (hit & key_pressed & (key_value != hit_key));
    assign verdict       = frame_verdict(samp_hit, samp_conflict);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            hit       <= 1'b0;
            hit_key   <= '0;
            conflict  <= 1'b0;
        end else if (frame_wrap) begin
            frame_cnt <= '0;
            hit       <= 1'b0;
            hit_key   <= '0;
            conflict  <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (key_pressed) begin
                if (!hit) begin
                    hit     <= 1'b1;
                    hit_key <= key_value;
                end else if (key_value != hit_key) begin
                    conflict <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_n;
    logic [3:0] cand;
    logic [3:0] cand_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [4:0] cnt_inc;
    logic       emit;
    logic       emit_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW:0] REPEAT_N = (RW + 1)'(REPEAT_FRAMES);
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_n;
    logic [RW:0]   rep_inc;
    assign rep_inc = {1'b0, rep_cnt} + 1'b1;
`endif

    assign cnt_inc = {1'b0, cnt} + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= rep_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_n = rep_cnt;
`endif
        if (frame_wrap) begin
            case (state)
                IDLE: begin
                    if (verdict == KEY) begin
                        cand_n = samp_key;
                        cnt_n  = 4'd1;
                        if (STABLE_FRAMES == 1) begin
                            state_n = HELD;
                            emit    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_n = '0;
`endif
                        end else begin
                            state_n = CAND;
                        end
                    end
                end
                CAND: begin
                    if (verdict == KEY) begin
                        if (samp_key == cand) begin
                            cnt_n = cnt_inc[3:0];
                            if (cnt_inc >= STABLE_N) begin
                                state_n = HELD;
                                emit    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_n = '0;
`endif
                            end
                        end else begin
                            cand_n = samp_key;
                            cnt_n  = 4'd1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (verdict == NONE) begin
                        state_n = IDLE;
                    end else if (verdict == KEY) begin
                        if (samp_key == cand) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rep_inc >= REPEAT_N) begin
                                emit      = 1'b1;
                                rep_cnt_n = '0;
                            end else begin
                                rep_cnt_n = rep_inc[RW-1:0];
                            end
`endif
                        end else begin
                            cand_n  = samp_key;
                            cnt_n   = 4'd1;
                            // With single-frame acceptance the new key is
                            // already stable; otherwise it starts as a
                            // fresh candidate.
                            if (STABLE_FRAMES == 1) begin
                                emit = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_cnt_n = '0;
`endif
                            end else begin
                                state_n = CAND;
                            end
                        end
                    end
                    // CONFLICT while HELD: keep holding, no event.
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        held      = (state == HELD);
        held_key  = (state == HELD) ? cand : 4'h0;
        dbg_state = state;
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    logic       fifo_pop;
    logic [3:0] fifo_dout;

    // The push lands one cycle after the verdict. cand cannot change in
    // that cycle because the next verdict is at least 8 cycles away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            emit_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            emit_q   <= emit;
            overflow <= fifo_drop;
        end
    end

    assign fifo_pop = ~fifo_empty & evt.evt_ready;

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (emit_q),
        .din   (cand),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_key   = fifo_dout;

endmodule

// File: tb/tb_keypad_event_filter.sv
// tb_keypad_event_filter: directed, table-driven bench for keypad_event_filter
// with a short frame (16 cycles), STABLE_FRAMES=3, FIFO_DEPTH=4 and
// REPEAT_FRAMES=2. Define KEYPAD_AUTOREPEAT_EN on both bench and RTL to
// exercise the auto-repeat build.
module tb_keypad_event_filter;
    import keypad_pkg::*;

    localparam int FC = 16;
    localparam int SF = 3;
    localparam int FD = 4;
    localparam int RF = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] key_value;
    logic       key_pressed;
    logic       held;
    logic [3:0] held_key;
    logic       overflow;
    state_t     dbg_state;

    keypad_event_filter_if evt_if();

    keypad_event_filter #(
        .FRAME_CYCLES  (FC),
        .STABLE_FRAMES (SF),
        .FIFO_DEPTH    (FD),
        .REPEAT_FRAMES (RF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_value   (key_value),
        .key_pressed (key_pressed),
        .evt         (evt_if.master),
        .held        (held),
        .held_key    (held_key),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    int         ph     = 0;
    int         ovf_cnt;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    // Record every completed transfer and every overflow pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1)
            got_q.push_back(evt_if.evt_key);
        if (rst_n === 1'b1 && overflow === 1'b1)
            ovf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_queue(input string name);
        int n;
        check($sformatf("%s_count", name), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_evt%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    // ---------------- driver tasks ----------------
    // Column 0 carries key k, column 2 carries key k2; other columns idle.
    task automatic tick(input logic [3:0] k, input logic p, input logic [3:0] k2, input logic p2);
        int col;
        col = ph % 4;
        if (col == 0 && p) begin
            key_pressed = 1'b1;
            key_value   = k;
        end else if (col == 2 && p2) begin
            key_pressed = 1'b1;
            key_value   = k2;
        end else begin
            key_pressed = 1'b0;
            key_value   = 4'h0;
        end
        @(posedge clk);
        #1;
        ph = (ph + 1) % FC;
    endtask

    // Runs n frames (the first one may be the remainder of a partial frame).
    // Returns one cycle after the last verdict edge.
    task automatic frames(input logic [3:0] k, input logic p, input logic [3:0] k2,
                          input logic p2, input int n);
        for (int f = 0; f < n; f++) begin
            tick(k, p, k2, p2);
            while (ph != 0) tick(k, p, k2, p2);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick(4'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        key_pressed = 1'b0;
        key_value   = 4'h0;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph    = 0;
        got_q.delete();
        exp_q.delete();
        ovf_cnt = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] k;
        logic       p;
        logic [3:0] k2;
        logic       p2;
        int         n;
        logic       exp_held;
        logic [3:0] exp_key;
        logic       evt;
    } row_t;

    row_t rows[17];

    initial begin
        rst_n          = 1'b0;
        key_pressed    = 1'b0;
        key_value      = 4'h0;
        evt_if.evt_ready = 1'b0;
        ovf_cnt        = 0;

        // ---- reset state ----
        do_reset();
        check("rst_evt_valid", 32'(evt_if.evt_valid), 0);
        check("rst_evt_key",   32'(evt_if.evt_key),   0);
        check("rst_held",      32'(held),             0);
        check("rst_held_key",  32'(held_key),         0);
        check("rst_overflow",  32'(overflow),         0);
        check("rst_state",     32'(dbg_state),        32'(IDLE));

        // ---- single press timing, consumer stalled ----
        frames(KEY_RIGHT, 1'b1, 4'h0, 1'b0, 3);
        check("a_held_rise",     32'(held),             1);
        check("a_held_key",      32'(held_key),         32'(KEY_RIGHT));
        check("a_valid_not_yet", 32'(evt_if.evt_valid), 0);
        tick(KEY_RIGHT, 1'b1, 4'h0, 1'b0);
        check("a_valid_rise",    32'(evt_if.evt_valid), 1);
        check("a_evt_key",       32'(evt_if.evt_key),   32'(KEY_RIGHT));
        for (int i = 0; i < 3; i++) tick(KEY_RIGHT, 1'b1, 4'h0, 1'b0);
        check("a_valid_stable",  32'(evt_if.evt_valid), 1);
        check("a_key_stable",    32'(evt_if.evt_key),   32'(KEY_RIGHT));
        frames(KEY_RIGHT, 1'b1, 4'h0, 1'b0, 1);
        check("a_still_held",    32'(held),             1);
        frames(4'h0, 1'b0, 4'h0, 1'b0, 1);
        check("a_held_fall",     32'(held),             0);
        evt_if.evt_ready = 1'b1;
        idle_cycles(3);
        exp_q.push_back(KEY_RIGHT);
        check_queue("a_drain");
        check("a_empty_after",   32'(evt_if.evt_valid), 0);

        // ---- table-driven frame sequences, consumer always ready ----
        rows[0]  = '{KEY_RIGHT, 1'b1, 4'h0,     1'b0, 3, 1'b1, KEY_RIGHT, 1'b1};
        rows[1]  = '{4'h0,      1'b0, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[2]  = '{KEY_UP,    1'b1, 4'h0,     1'b0, 2, 1'b0, 4'h0,      1'b0};
        rows[3]  = '{4'h0,      1'b0, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[4]  = '{KEY_UP,    1'b1, 4'h0,     1'b0, 3, 1'b1, KEY_UP,    1'b1};
        rows[5]  = '{KEY_UP,    1'b1, KEY_DOWN, 1'b1, 1, 1'b1, KEY_UP,    1'b0};
        rows[6]  = '{KEY_UP,    1'b1, 4'h0,     1'b0, 1, 1'b1, KEY_UP,    1'b0};
        rows[7]  = '{KEY_DOWN,  1'b1, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[8]  = '{KEY_DOWN,  1'b1, 4'h0,     1'b0, 2, 1'b1, KEY_DOWN,  1'b1};
        rows[9]  = '{4'h0,      1'b0, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[10] = '{KEY_UP,    1'b1, KEY_DOWN, 1'b1, 2, 1'b0, 4'h0,      1'b0};
        rows[11] = '{KEY_LEFT,  1'b1, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[12] = '{KEY_RIGHT, 1'b1, 4'h0,     1'b0, 2, 1'b0, 4'h0,      1'b0};
        rows[13] = '{KEY_RIGHT, 1'b1, 4'h0,     1'b0, 1, 1'b1, KEY_RIGHT, 1'b1};
        rows[14] = '{4'h0,      1'b0, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};
        rows[15] = '{KEY_LEFT,  1'b1, KEY_LEFT, 1'b1, 3, 1'b1, KEY_LEFT,  1'b1};
        rows[16] = '{4'h0,      1'b0, 4'h0,     1'b0, 1, 1'b0, 4'h0,      1'b0};

        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int r = 0; r < 17; r++) begin
            frames(rows[r].k, rows[r].p, rows[r].k2, rows[r].p2, rows[r].n);
            check($sformatf("t%0d_held", r),     32'(held),     32'(rows[r].exp_held));
            check($sformatf("t%0d_held_key", r), 32'(held_key), 32'(rows[r].exp_key));
            if (rows[r].evt) exp_q.push_back(rows[r].k);
        end
        idle_cycles(4);
        check_queue("t_events");
        check("t_no_overflow", 32'(ovf_cnt), 0);

        // ---- overflow: five presses into a 4-deep FIFO ----
        do_reset();
        evt_if.evt_ready = 1'b0;
        begin
            logic [3:0] keys[5];
            keys = '{KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP};
            for (int i = 0; i < 5; i++) begin
                frames(keys[i], 1'b1, 4'h0, 1'b0, 3);
                frames(4'h0, 1'b0, 4'h0, 1'b0, 1);
            end
        end
        check("b_ovf_pulses", 32'(ovf_cnt),           1);
        check("b_full_valid", 32'(evt_if.evt_valid), 1);
        check("b_full_head",  32'(evt_if.evt_key),    32'(KEY_UP));
        // Sixth press lands while full, with a pop in the same cycle.
        frames(KEY_LEFT, 1'b1, 4'h0, 1'b0, 3);
        evt_if.evt_ready = 1'b1;
        tick(4'h0, 1'b0, 4'h0, 1'b0);
        evt_if.evt_ready = 1'b0;
        idle_cycles(4);
        check("b_no_drop_on_pop", 32'(ovf_cnt), 1);
        evt_if.evt_ready = 1'b1;
        idle_cycles(8);
        exp_q = '{KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_LEFT};
        check_queue("b_drain");

        // ---- reset mid-frame with events queued ----
        do_reset();
        evt_if.evt_ready = 1'b0;
        frames(KEY_UP, 1'b1, 4'h0, 1'b0, 3);
        frames(4'h0, 1'b0, 4'h0, 1'b0, 1);
        frames(KEY_DOWN, 1'b1, 4'h0, 1'b0, 3);
        for (int i = 0; i < 5; i++) tick(KEY_DOWN, 1'b1, 4'h0, 1'b0);
        check("c_pre_valid", 32'(evt_if.evt_valid), 1);
        check("c_pre_held",  32'(held),             1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("c_rst_valid",    32'(evt_if.evt_valid), 0);
        check("c_rst_held",     32'(held),             0);
        check("c_rst_held_key", 32'(held_key),         0);
        check("c_rst_evt_key",  32'(evt_if.evt_key),   0);
        rst_n = 1'b1;
        ph    = 0;
        frames(KEY_DOWN, 1'b1, 4'h0, 1'b0, 2);
        check("c_two_frames_held",  32'(held),             0);
        check("c_two_frames_valid", 32'(evt_if.evt_valid), 0);
        frames(KEY_DOWN, 1'b1, 4'h0, 1'b0, 1);
        check("c_third_frame_held", 32'(held),             1);
        tick(KEY_DOWN, 1'b1, 4'h0, 1'b0);
        check("c_new_valid", 32'(evt_if.evt_valid), 1);
        check("c_new_key",   32'(evt_if.evt_key),   32'(KEY_DOWN));

        // ---- long hold: auto-repeat or single event ----
        do_reset();
        evt_if.evt_ready = 1'b1;
        frames(KEY_LEFT, 1'b1, 4'h0, 1'b0, 7);
        check("d_held", 32'(held), 1);
        frames(4'h0, 1'b0, 4'h0, 1'b0, 1);
        idle_cycles(4);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q = '{KEY_LEFT, KEY_LEFT, KEY_LEFT};
`else
        exp_q = '{KEY_LEFT};
`endif
        check_queue("d_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_event_filter.md
Name: keypad_event_filter

Overview:
Sits directly downstream of the 4x4 column-scanning keypad decoder. It consumes the decoder's per-column key_value/key_pressed levels and converts them into debounced, single-shot key-press events. Each scan frame (4 columns) is reduced to one verdict. A key must be stable for STABLE_FRAMES frames before one event is pushed into a small FIFO. The game logic drains events over a valid/ready handshake and also sees a debounced "held" level for sustained-step judging.

Parameters:
FRAME_CYCLES, 400000, clk cycles per full scan frame (4 columns x 1 ms at 100 MHz); must be >= 8
STABLE_FRAMES, 3, consecutive identical frames needed to accept a press; range 1..15
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2
REPEAT_FRAMES, 50, frames between auto-repeat events (used only with KEYPAD_AUTOREPEAT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
key_value  in  4  decoded key code from scanner
key_pressed  in  1  scanner's "key seen in current column" level
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts head event
evt_key  out  4  head event key code
held  out  1  debounced key-held level
held_key  out  4  key code while held is 1 (0 otherwise)
overflow  out  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Reset (rst_n=0 at posedge): frame counter=0, frame flags cleared, state=IDLE, FIFO empty. Outputs: evt_valid=0, evt_key=0, held=0, held_key=0, overflow=0. Reset mid-frame discards that partial frame and any queued events.
- Frame accumulation: frame counter runs 0..FRAME_CYCLES-1 and wraps.
  - On each cycle with key_pressed=1: if there is no hit yet, set hit=1 and capture key_value.
  - If there is already a hit and key_value differs from the captured value, set conflict=1.
- Frame verdict: computed in the wrap cycle, including that cycle's sample. Verdict is NONE (no hit), CONFLICT, or KEY(k). Flags clear for the next frame in the same cycle.
- FSM (states IDLE, CAND, HELD), evaluated only on the verdict cycle:
  - IDLE + KEY(k): cand=k, cnt=1. If STABLE_FRAMES==1, go to HELD and emit; otherwise go to CAND.
  - IDLE + NONE or CONFLICT: stay in IDLE.
  - CAND + KEY(cand): cnt+1. When cnt reaches STABLE_FRAMES, go to HELD and emit cand.
  - CAND + KEY(other): cand=other, cnt=1.
  - CAND + NONE or CONFLICT: go to IDLE.
  - HELD + KEY(held_key): stay. HELD + CONFLICT: stay, no event.
  - HELD + NONE: go to IDLE; held falls in the next cycle.
  - HELD + KEY(other): go to CAND with cand=other, cnt=1; held falls.
- held/held_key are registered: they rise 1 cycle after the emitting verdict cycle and fall 1 cycle after the leaving verdict cycle.
- Emit: push into FIFO in the cycle after the verdict; evt_valid rises the following cycle.
  - Push while full with no simultaneous pop: event dropped, overflow=1 for one cycle.
  - Push while full with a simultaneous pop (evt_valid & evt_ready): both occur and nothing is dropped.
  - Pop while empty: ignored.
- FIFO is first-word-fall-through: evt_key holds the head entry whenever evt_valid=1. evt_key and evt_valid are stable while evt_ready=0.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, a repeat counter counts verdict frames. Every REPEAT_FRAMES frames of KEY(held_key), a repeat event with the same key is emitted under the same FIFO and overflow rules. The counter clears on entry to HELD.
- Undefined: exactly one event per accepted press; the repeat counter is absent.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum (IDLE, CAND, HELD) and frame verdict enum (NONE, CONFLICT, KEY).
  - Key code constants for the game arrows: KEY_UP=4'h2, KEY_LEFT=4'h4, KEY_RIGHT=4'h6, KEY_DOWN=4'h8.
  - Default FRAME_CYCLES.
- One sub-module, keypad_event_fifo: FWFT FIFO with push, pop, full and empty, parameterised by FIFO_DEPTH and width 4.

Test Plan:
- Hold key 4'h6 for 3 full frames (FRAME_CYCLES=16 in bench), then no ready → exactly one event with evt_key=6. held=1 from 1 cycle after the 3rd verdict; evt_valid rises 2 cycles after the 3rd verdict.
- Press 4'h2 for only 2 frames, then release → no event; held stays 0.
- 5 accepted presses (2,4,6,8,2) with evt_ready=0 and FIFO_DEPTH=4 → entries 2,4,6,8 retained, one overflow pulse on the 5th push. Draining then yields 2,4,6,8.
- 4'h2 and 4'h8 both hit in one frame → CONFLICT. From IDLE: no event. From HELD(2): held stays 1, no event.
- Assert rst_n=0 mid-frame with 2 events queued → next cycle evt_valid=0, held=0. The next press needs a full STABLE_FRAMES again.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_FRAMES=2, hold 4'h4 for 7 frames → events at frames 3, 5, 7 (3 events, all 4).
